data_mem_arbiter: RTL and testbench

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

---
 rtl/data_mem_arbiter.sv | 154 +++++++++++++++
 tb/tb_data_mem_arbiter.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_arbiter.sv
// Two-master arbiter (core + external) in front of a single-port data memory, with timeout and sticky bus_err.
// Define ARB_ROUND_ROBIN_EN for alternating grants on contention; otherwise the core has fixed priority.
module data_mem_arbiter #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       core_rd,
    input  logic       core_wr,
    input  logic [4:0] core_addr,
    input  logic [7:0] core_wdata,
    output logic [7:0] core_rdata,
    output logic       core_stall,
    input  logic       ext_req,
    input  logic       ext_we,
    input  logic [4:0] ext_addr,
    input  logic [7:0] ext_wdata,
    output logic       ext_ack,
    output logic [7:0] ext_rdata,
    output logic       mem_en,
    output logic       mem_we,
    output logic [4:0] mem_addr,
    output logic [7:0] mem_wdata,
    input  logic [7:0] mem_rdata,
    input  logic       mem_ready,
    output logic       bus_err
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;
    typedef enum logic {OWN_CORE, OWN_EXT} owner_e;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_e     state_q, state_d;
    owner_e     owner_q, owner_d;
    logic       we_q, we_d;
    logic [4:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic [7:0] rdata_q, rdata_d;
    logic [7:0] cnt_q, cnt_d;
    logic       bus_err_q, bus_err_d;
    logic       core_req;
    logic       grant_ext;

`ifdef ARB_ROUND_ROBIN_EN
    owner_e last_q, last_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) last_q <= OWN_EXT;
        else        last_q <= last_d;
    end
`endif

    always_comb begin
        core_req  = core_rd | core_wr;
        grant_ext = 1'b0;
        if (core_req && ext_req) begin
`ifdef ARB_ROUND_ROBIN_EN
            grant_ext = (last_q == OWN_CORE);
`else
            grant_ext = 1'b0;
`endif
        end else begin
            grant_ext = ext_req;
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        cnt_d     = cnt_q;
        bus_err_d = bus_err_q;
`ifdef ARB_ROUND_ROBIN_EN
        last_d    = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (core_req || ext_req) begin
                    state_d = ACCESS;
                    cnt_d   = '0;
                    if (grant_ext) begin
                        owner_d = OWN_EXT;
                        we_d    = ext_we;
                        addr_d  = ext_addr;
                        wdata_d = ext_wdata;
                    end else begin
                        owner_d = OWN_CORE;
                        we_d    = core_wr;
                        addr_d  = core_addr;
                        wdata_d = core_wdata;
                    end
`ifdef ARB_ROUND_ROBIN_EN
                    last_d = grant_ext ? OWN_EXT : OWN_CORE;
`endif
                end
            end
            ACCESS: begin
                // Completion on the last allowed cycle wins over the timeout.
                if (mem_ready) begin
                    if (!we_q) rdata_d = mem_rdata;
                    state_d = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    rdata_d   = 8'hFF;
                    bus_err_d = 1'b1;
                    state_d   = RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            owner_q   <= OWN_CORE;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            cnt_q     <= cnt_d;
            bus_err_q <= bus_err_d;
        end
    end

    // Memory command is driven purely from latched values and forced to zero outside ACCESS.
    always_comb begin
        mem_en     = (state_q == ACCESS);
        mem_we     = mem_en & we_q;
        mem_addr   = mem_en ? addr_q : '0;
        mem_wdata  = mem_en ? wdata_q : '0;
        ext_ack    = (state_q == RESP) && (owner_q == OWN_EXT);
        core_stall = core_req & ~((state_q == RESP) && (owner_q == OWN_CORE));
        core_rdata = rdata_q;
        ext_rdata  = rdata_q;
        bus_err    = bus_err_q;
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Randomized scoreboard bench for data_mem_arbiter: a transaction-level model predicts grant order,
// memory commands and responses; a memory responder with queued latencies serves the DUT.
module tb_data_mem_arbiter;

    localparam int unsigned TIMEOUT = 15;

    logic       clk = 1'b0;
    logic       reset;
    logic       core_rd, core_wr;
    logic [4:0] core_addr;
    logic [7:0] core_wdata;
    logic [7:0] core_rdata;
    logic       core_stall;
    logic       ext_req, ext_we;
    logic [4:0] ext_addr;
    logic [7:0] ext_wdata;
    logic       ext_ack;
    logic [7:0] ext_rdata;
    logic       mem_en, mem_we;
    logic [4:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       mem_ready;
    logic       bus_err;

    data_mem_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .core_rd(core_rd), .core_wr(core_wr), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_rdata(core_rdata), .core_stall(core_stall),
        .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_ack(ext_ack), .ext_rdata(ext_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [7:0] rdata; logic err; } resp_t;
    typedef struct packed { logic we; logic [4:0] addr; logic [7:0] wdata; logic [15:0] len; } cmd_t;

    resp_t core_exp[$];
    resp_t ext_exp[$];
    cmd_t  cmd_exp[$];
    int    lat_q[$];

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [7:0] ref_mem[32];
    logic [7:0] mem_arr[32];
    logic [7:0] m_rdata;
    logic       m_err;
    bit         m_last_ext;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic expire(input string name);
        checks++;
        errors++;
        $display("FAIL %s wait bound expired", name);
    endtask

    function automatic bit ext_wins_contention();
`ifdef ARB_ROUND_ROBIN_EN
        return !m_last_ext;
`else
        return 1'b0;
`endif
    endfunction

    function automatic void model_txn(input bit is_ext, input bit we, input logic [4:0] a,
                                      input logic [7:0] d, input int lat);
        cmd_t  c;
        resp_t r;
        bit    tmo;
        tmo     = (lat >= int'(TIMEOUT));
        c.we    = we;
        c.addr  = a;
        c.wdata = d;
        c.len   = tmo ? 16'(TIMEOUT) : 16'(lat + 1);
        if (tmo) begin
            m_rdata = 8'hFF;
            m_err   = 1'b1;
        end else if (!we) begin
            m_rdata = ref_mem[a];
        end else begin
            ref_mem[a] = d;
        end
        r.rdata = m_rdata;
        r.err   = m_err;
        cmd_exp.push_back(c);
        lat_q.push_back(lat);
        if (is_ext) ext_exp.push_back(r);
        else        core_exp.push_back(r);
        m_last_ext = is_ext;
    endfunction

    function automatic void model_reset();
        m_rdata    = 8'h00;
        m_err      = 1'b0;
        m_last_ext = 1'b1;
    endfunction

    // Memory device: each new command takes the next queued latency
    bit busy = 1'b0;
    int wl   = 0;
    always @(negedge clk) begin
        if (!reset) begin
            busy      = 1'b0;
            mem_ready = 1'b0;
        end else if (mem_en) begin
            if (!busy) begin
                busy = 1'b1;
                wl   = (lat_q.size() != 0) ? lat_q.pop_front() : 0;
            end
            if (wl == 0) begin
                mem_ready = 1'b1;
                mem_rdata = mem_arr[mem_addr];
                if (mem_we) mem_arr[mem_addr] = mem_wdata;
            end else begin
                wl--;
                mem_ready = 1'b0;
                mem_rdata = 8'($urandom);
            end
        end else begin
            busy      = 1'b0;
            mem_ready = 1'b0;
        end
    end

    // Monitor: compares every response and memory command against the scoreboard
    bit   prev_en = 1'b0, prev_ack = 1'b0, cur_valid = 1'b0;
    int   en_cnt = 0;
    cmd_t cur;
    always @(negedge clk) begin
        if (!reset) begin
            prev_en   = 1'b0;
            prev_ack  = 1'b0;
            cur_valid = 1'b0;
        end else begin
            if (mem_en && !prev_en) begin
                en_cnt = 1;
                if (cmd_exp.size() == 0) begin
                    expire("cmd_unexpected");
                    cur_valid = 1'b0;
                end else begin
                    cur       = cmd_exp.pop_front();
                    cur_valid = 1'b1;
                    chk("mem_we", 32'(mem_we), 32'(cur.we));
                    chk("mem_addr", 32'(mem_addr), 32'(cur.addr));
                    if (cur.we) chk("mem_wdata", 32'(mem_wdata), 32'(cur.wdata));
                end
            end else if (mem_en) begin
                en_cnt++;
            end else if (prev_en && cur_valid) begin
                chk("mem_en_len", 32'(en_cnt), 32'(cur.len));
                cur_valid = 1'b0;
            end
            prev_en = mem_en;

            if (ext_ack) begin
                if (prev_ack) expire("ext_ack_multi_cycle");
                if (ext_exp.size() == 0) expire("ext_ack_unexpected");
                else begin
                    resp_t r;
                    r = ext_exp.pop_front();
                    chk("ext_rdata", 32'(ext_rdata), 32'(r.rdata));
                    chk("ext_bus_err", 32'(bus_err), 32'(r.err));
                end
            end
            prev_ack = ext_ack;

            if ((core_rd || core_wr) && !core_stall) begin
                if (core_exp.size() == 0) expire("core_resp_unexpected");
                else begin
                    resp_t r;
                    r = core_exp.pop_front();
                    chk("core_rdata", 32'(core_rdata), 32'(r.rdata));
                    chk("core_bus_err", 32'(bus_err), 32'(r.err));
                end
            end
        end
    end

    task automatic do_core(input bit rd, input bit wr, input logic [4:0] a, input logic [7:0] d,
                           output int stalls);
        bit done = 1'b0;
        core_rd = rd; core_wr = wr; core_addr = a; core_wdata = d;
        #1;
        stalls = core_stall ? 1 : 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (!core_stall) begin done = 1'b1; break; end
            stalls++;
        end
        if (!done) expire("core_wait");
        @(posedge clk); #1;
        core_rd = 1'b0; core_wr = 1'b0;
        core_addr = 5'($urandom); core_wdata = 8'($urandom);
    endtask

    task automatic do_ext(input bit we, input logic [4:0] a, input logic [7:0] d);
        bit done = 1'b0;
        ext_req = 1'b1; ext_we = we; ext_addr = a; ext_wdata = d;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (ext_ack) begin done = 1'b1; break; end
        end
        if (!done) expire("ext_wait");
        ext_req = 1'b0;
        ext_we = 1'($urandom); ext_addr = 5'($urandom); ext_wdata = 8'($urandom);
    endtask

    function automatic int rand_lat();
        return ($urandom_range(0, 9) == 0) ? int'(TIMEOUT) + int'($urandom_range(0, 3))
                                           : int'($urandom_range(0, 4));
    endfunction

    // kind: 0 core only, 1 ext only, 2 both in the same cycle
    task automatic round(input int kind, input bit crd, input bit cwr, input logic [4:0] ca,
                         input logic [7:0] cd, input int clat, input bit ewe, input logic [4:0] ea,
                         input logic [7:0] ed, input int elat);
        int  st;
        bit  cwe;
        cwe = cwr;
        if (kind == 0) begin
            model_txn(1'b0, cwe, ca, cd, clat);
            do_core(crd, cwr, ca, cd, st);
        end else if (kind == 1) begin
            model_txn(1'b1, ewe, ea, ed, elat);
            do_ext(ewe, ea, ed);
        end else begin
            if (ext_wins_contention()) begin
                model_txn(1'b1, ewe, ea, ed, elat);
                model_txn(1'b0, cwe, ca, cd, clat);
            end else begin
                model_txn(1'b0, cwe, ca, cd, clat);
                model_txn(1'b1, ewe, ea, ed, elat);
            end
            fork
                do_core(crd, cwr, ca, cd, st);
                do_ext(ewe, ea, ed);
            join
        end
        chk("core_rdata_hold", 32'(core_rdata), 32'(m_rdata));
        chk("ext_rdata_hold", 32'(ext_rdata), 32'(m_rdata));
        chk("bus_err_sticky", 32'(bus_err), 32'(m_err));
    endtask

    initial begin
        int st;
        bit found;
        reset = 1'b0;
        core_rd = 1'b1; core_wr = 1'b0; core_addr = '0; core_wdata = '0;
        ext_req = 1'b0; ext_we = 1'b0; ext_addr = '0; ext_wdata = '0;
        mem_ready = 1'b0; mem_rdata = '0;
        for (int i = 0; i < 32; i++) begin
            ref_mem[i] = 8'($urandom);
            mem_arr[i] = ref_mem[i];
        end
        ref_mem[3] = 8'h5A; mem_arr[3] = 8'h5A;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        chk("rst_core_stall", 32'(core_stall), 32'd1);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_ext_ack", 32'(ext_ack), 32'd0);
        chk("rst_core_rdata", 32'(core_rdata), 32'd0);
        chk("rst_ext_rdata", 32'(ext_rdata), 32'd0);
        chk("rst_bus_err", 32'(bus_err), 32'd0);
        core_rd = 1'b0;
        #1;
        chk("rst_core_stall_idle", 32'(core_stall), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;

        // Core read of 5'h03 with immediate ready: two stall cycles
        model_txn(1'b0, 1'b0, 5'h03, 8'h00, 0);
        do_core(1'b1, 1'b0, 5'h03, 8'h00, st);
        chk("core_read_stall_cycles", 32'(st), 32'd2);
        chk("core_read_5a", 32'(core_rdata), 32'h5A);

        // Ext write 1F/C3 with three wait cycles
        round(1, 1'b0, 1'b0, 5'h0, 8'h0, 0, 1'b1, 5'h1F, 8'hC3, 3);
        chk("mem_1f_written", 32'(mem_arr[31]), 32'hC3);

        // Repeated contention
        for (int i = 0; i < 4; i++)
            round(2, 1'b1, 1'b0, 5'(i), 8'h0, 0, 1'b0, 5'(i + 8), 8'h0, 1);

        // Timeout: never ready, then bus_err must persist
        round(0, 1'b1, 1'b0, 5'h07, 8'h00, 100, 1'b0, 5'h0, 8'h0, 0);
        chk("timeout_rdata", 32'(core_rdata), 32'hFF);
        round(1, 1'b0, 1'b0, 5'h0, 8'h0, 0, 1'b0, 5'h03, 8'h0, 0);

        for (int n = 0; n < 60; n++) begin
            bit [1:0] sel;
            sel = 2'($urandom_range(0, 2));
            round(int'($urandom_range(0, 2)), sel != 2'd1, sel != 2'd0, 5'($urandom), 8'($urandom),
                  rand_lat(), 1'($urandom), 5'($urandom), 8'($urandom), rand_lat());
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        // Reset in the middle of an ext ACCESS
        begin
            cmd_t c;
            c.we = 1'b0; c.addr = 5'h05; c.wdata = 8'h00; c.len = 16'd0;
            cmd_exp.push_back(c);
            lat_q.push_back(100);
            ext_req = 1'b1; ext_we = 1'b0; ext_addr = 5'h05; ext_wdata = 8'h00;
            found = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(posedge clk); #1;
                if (mem_en) begin found = 1'b1; break; end
            end
            if (!found) expire("abort_mem_en_wait");
            repeat (2) @(posedge clk);
            #1;
            reset = 1'b0;
            #1;
            chk("abort_mem_en", 32'(mem_en), 32'd0);
            chk("abort_mem_addr", 32'(mem_addr), 32'd0);
            chk("abort_ext_ack", 32'(ext_ack), 32'd0);
            chk("abort_bus_err", 32'(bus_err), 32'd0);
            chk("abort_rdata", 32'(ext_rdata), 32'd0);
            ext_req = 1'b0;
            model_reset();
            repeat (2) @(posedge clk);
            #1;
            chk("abort_no_ack", 32'(ext_ack), 32'd0);
            reset = 1'b1;
        end
        round(1, 1'b0, 1'b0, 5'h0, 8'h0, 0, 1'b0, 5'h03, 8'h0, 2);
        round(2, 1'b1, 1'b0, 5'h1F, 8'h0, 0, 1'b0, 5'h03, 8'h0, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("core_queue_drained", 32'(core_exp.size()), 32'd0);
        chk("ext_queue_drained", 32'(ext_exp.size()), 32'd0);
        chk("cmd_queue_drained", 32'(cmd_exp.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
